// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, boot image and FSM state type for mem_responder
package mem_pkg;
  localparam logic [15:0] OP_READ  = 16'd0;
  localparam logic [15:0] OP_WRITE = 16'd1;
  localparam logic [15:0] OP_ADD   = 16'd2;
  localparam logic [15:0] OP_JUMP  = 16'd3;
  localparam logic [14:0] PROG_BASE_DEF = 15'd9216;
  // Entry i sits in word i (entry 0 is the least significant word); entries past 3 are zero.
  localparam logic [15:0][15:0] BOOT_ROM = {192'd0, OP_JUMP, OP_WRITE, OP_ADD, OP_READ};
  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/sp_ram_32kx16.sv
// sp_ram_32kx16: 32768x16 single-port synchronous RAM, write-first, registered read, no reset
// Ports: clk_i clock; we_i write enable; addr_i word address; wdata_i write data; rdata_o read data
module sp_ram_32kx16 (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [14:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o
);
  logic [15:0] mem [32768];
  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= we_i ? wdata_i : mem[addr_i];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed 16-bit RAM responder for Core, with boot-program load after reset
// Ports: clock; reset_n async active-low; addrin/datain/we from Core; dataout registered read data;
//        ready high once the boot image is loaded; write_fault one-cycle pulse on a dropped write.
// Optional feature: define MEM_WRITE_PROTECT_EN to reject RUN-state writes into the boot window.
module mem_responder
  import mem_pkg::*;
#(
  parameter logic [14:0] PROG_BASE    = PROG_BASE_DEF,
  parameter int          PROG_LEN     = 4,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [14:0] addrin,
  input  logic [15:0] datain,
  input  logic        we,
  output logic [15:0] dataout,
  output logic        ready,
  output logic        write_fault
);
  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        prev_we_q;
  logic [14:0] prev_addr_q;
  logic        rd_valid_q;
  logic        run, qual, prot, ram_we;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata, rd_data;
  assign run = state_q == RUN;
  // A level-held we only writes again once the address moves.
  assign qual = we && (!prev_we_q || addrin != prev_addr_q);
`ifdef MEM_WRITE_PROTECT_EN
  logic [14:0] win_off;
  logic        fault_q;
  // Offset from the window base wraps mod 2^15, so one compare covers wrapped windows.
  assign win_off = addrin - PROG_BASE;
  assign prot = win_off < 15'(PROG_LEN);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fault_q <= 1'b0;
    else fault_q <= run && qual && prot;
  end
  assign write_fault = fault_q;
`else
  assign prot = 1'b0;
  assign write_fault = 1'b0;
`endif
  always_comb begin
    state_d   = (!run && idx_q == 4'(PROG_LEN - 1)) ? RUN : state_q;
    idx_d     = run ? idx_q : idx_q + 4'd1;
    ram_addr  = run ? addrin : PROG_BASE + 15'(idx_q);
    ram_wdata = run ? datain : BOOT_ROM[idx_q];
    ram_we    = !run || (qual && !prot);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= BOOT;
      idx_q       <= 4'd0;
      prev_we_q   <= 1'b0;
      prev_addr_q <= 15'd0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      prev_we_q   <= we;
      prev_addr_q <= addrin;
      rd_valid_q  <= run;
    end
  end
  sp_ram_32kx16 u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );
  // The RAM has no reset; its read register is masked until a RUN-cycle read lands in it.
  assign rd_data = rd_valid_q ? ram_rdata : 16'd0;
  assign ready = run;
  if (READ_LATENCY == 2) begin : g_lat2
    logic [15:0] dout_q;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) dout_q <= 16'd0;
      else dout_q <= rd_data;
    end
    assign dataout = dout_q;
  end else begin : g_lat1
    assign dataout = rd_data;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (boot, write qualification, protection, reset)
module tb_mem_responder;
  localparam int LAT = 1;
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  typedef struct {
    int          due;
    logic [14:0] a;
    logic [15:0] e;
  } exp_t;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [14:0] addrin;
  logic [15:0] datain;
  logic        we;
  logic [15:0] dataout;
  logic        ready;
  logic        write_fault;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb[$];
  mem_responder #(.READ_LATENCY(LAT)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .addrin      (addrin),
    .datain      (datain),
    .we          (we),
    .dataout     (dataout),
    .ready       (ready),
    .write_fault (write_fault)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t x;
      x = sb.pop_front();
      chk($sformatf("rd@%0d", x.a), dataout, x.e);
    end
  end
  // One RUN cycle: drive the bus and queue the value dataout must show LAT edges later.
  task automatic drive(input logic [14:0] a, input logic [15:0] d, input logic w, input logic [15:0] e);
    addrin = a;
    datain = d;
    we = w;
    sb.push_back('{cyc + LAT, a, e});
    @(negedge clock);
  endtask
  task automatic idle(input int n);
    we = 1'b0;
    repeat (n) @(negedge clock);
  endtask
  task automatic boot_check(input string tag);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      chk($sformatf("%s_ready_e%0d", tag, i), {15'd0, ready}, {15'd0, i == 4});
      if (i < 4) chk($sformatf("%s_dout_e%0d", tag, i), dataout, 16'd0);
    end
  endtask
  task automatic read_boot();
    drive(15'd9216, 16'd0, 1'b0, 16'd0);
    drive(15'd9217, 16'd0, 1'b0, 16'd2);
    drive(15'd9218, 16'd0, 1'b0, 16'd1);
    drive(15'd9219, 16'd0, 1'b0, 16'd3);
    idle(LAT + 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset_n = 1'b0;
    addrin = 15'd0;
    datain = 16'd0;
    we = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_dout", dataout, 16'd0);
    chk("rst_ready", {15'd0, ready}, 16'd0);
    chk("rst_fault", {15'd0, write_fault}, 16'd0);
    reset_n = 1'b1;
    boot_check("boot1");
    read_boot();
    drive(15'd100, 16'hBEEF, 1'b1, 16'hBEEF);
    chk("wf_beef", {15'd0, write_fault}, 16'd0);
    repeat (4) drive(15'd100, 16'hDEAD, 1'b1, 16'hBEEF);
    drive(15'd100, 16'h0000, 1'b0, 16'hBEEF);
    drive(15'd100, 16'h5555, 1'b1, 16'h5555);
    drive(15'd100, 16'h0000, 1'b0, 16'h5555);
    drive(15'd200, 16'h0011, 1'b1, 16'h0011);
    drive(15'd201, 16'h0022, 1'b1, 16'h0022);
    drive(15'd200, 16'h0000, 1'b0, 16'h0011);
    drive(15'd201, 16'h0000, 1'b0, 16'h0022);
    drive(15'd9217, 16'hFFFF, 1'b1, PROT ? 16'd2 : 16'hFFFF);
    chk("wf_pulse", {15'd0, write_fault}, {15'd0, PROT});
    drive(15'd9217, 16'hFFFF, 1'b1, PROT ? 16'd2 : 16'hFFFF);
    chk("wf_held", {15'd0, write_fault}, 16'd0);
    drive(15'd9217, 16'h0000, 1'b0, PROT ? 16'd2 : 16'hFFFF);
    drive(15'd9220, 16'h7777, 1'b1, 16'h7777);
    chk("wf_outside", {15'd0, write_fault}, 16'd0);
    drive(15'd50, 16'h1234, 1'b1, 16'h1234);
    drive(15'd50, 16'h0000, 1'b0, 16'h1234);
    idle(LAT + 1);
    chk("pre_rst_dout", dataout, 16'h1234);
    reset_n = 1'b0;
    #1;
    chk("run_rst_dout", dataout, 16'd0);
    chk("run_rst_ready", {15'd0, ready}, 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("midboot_ready", {15'd0, ready}, 16'd0);
    reset_n = 1'b0;
    #1;
    chk("midboot_rst_dout", dataout, 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    boot_check("boot2");
    drive(15'd50, 16'h0000, 1'b0, 16'h1234);
    drive(15'd9220, 16'h0000, 1'b0, 16'h7777);
    read_boot();
    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
